// File: rtl/data_mem_responder_pkg.sv
// data_mem_responder_pkg: shared word width and FSM state encoding
package data_mem_responder_pkg;
  localparam int WORD_LEN = 32;
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/data_mem_array.sv
// data_mem_array: single-port word array, synchronous write and clear, combinational read
module data_mem_array #(
  parameter int W = 32,
  parameter int DEPTH = 64,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          we,
  input  logic [AW-1:0] idx,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [DEPTH];
  // clear wins over a write in the same cycle
  always_ff @(posedge clk)
    if (clr)
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    else if (we)
      mem[idx] <= wdata;
  assign rdata = mem[idx];
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: multi-cycle data memory with ready handshake and range check
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter logic [WORD_LEN-1:0] BASE_ADDR = 1024,
  parameter int LATENCY = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                MEM_R_EN,
  input  logic                MEM_W_EN,
  input  logic [WORD_LEN-1:0] address,
  input  logic [WORD_LEN-1:0] dataIn,
  output logic [WORD_LEN-1:0] dataOut,
  output logic                ready,
  output logic                busy,
  output logic                addr_err
);
  localparam int W = WORD_LEN;
  localparam int AW = $clog2(DEPTH);
  state_t state, nxt;
  logic [3:0] cnt;
  logic lat_we, req, idle, eff_we, in_range, go_done;
  logic [W-1:0] lat_addr, lat_din, eff_addr, eff_din, rdata;
  logic [W-3:0] word;
  // in IDLE the live request is used so a single-cycle latency can complete on the capture edge
  always_comb begin
    req = MEM_R_EN | MEM_W_EN;
    idle = state == IDLE;
    eff_we = idle ? MEM_W_EN : lat_we;
    eff_addr = idle ? address : lat_addr;
    eff_din = idle ? dataIn : lat_din;
    word = eff_addr[W-1:2] - BASE_ADDR[W-1:2];
    in_range = eff_addr >= BASE_ADDR && word < (W-2)'(DEPTH);
    go_done = idle ? req && LATENCY == 1 : state == BUSY && cnt == 4'd1;
    nxt = go_done ? DONE : (idle && req) || state == BUSY ? BUSY : IDLE;
  end
  data_mem_array #(.W(W), .DEPTH(DEPTH)) u_array (
    .clk  (clk),
    .clr  (~rst),
    .we   (go_done & eff_we & in_range),
    .idx  (word[AW-1:0]),
    .wdata(eff_din),
    .rdata(rdata)
  );
  // FSM, latency counter, request latch and registered handshake outputs
  always_ff @(posedge clk)
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      ready <= 1'b0;
      busy <= 1'b0;
      addr_err <= 1'b0;
      dataOut <= '0;
      lat_we <= 1'b0;
      lat_addr <= '0;
      lat_din <= '0;
    end else begin
      state <= nxt;
      ready <= go_done;
      busy <= nxt == BUSY;
      addr_err <= go_done & ~in_range;
      cnt <= idle && req ? 4'(LATENCY - 1) : state == BUSY && cnt != 4'd0 ? cnt - 4'd1 : cnt;
      if (idle && req) begin
        lat_we <= MEM_W_EN;
        lat_addr <= address;
        lat_din <= dataIn;
      end
      if (go_done && !eff_we) dataOut <= in_range ? rdata : '0;
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed scoreboard bench for LATENCY=4 and LATENCY=1 instances
module tb_data_mem_responder;
  logic clk = 0, rst = 0;
  logic r_en = 0, w_en = 0, rdy, bsy, aerr;
  logic [31:0] addr = 0, din = 0, dout;
  logic r1 = 0, w1 = 0, rdy1, bsy1, aerr1;
  logic [31:0] a1 = 0, d1 = 0, dout1;
  int checks = 0, errors = 0;
  typedef struct {logic rd; logic [31:0] data; logic err;} exp_t;
  exp_t sb[$];
  logic [31:0] model [int];
  logic [31:0] last_rd = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.LATENCY(4)) u4 (
    .clk(clk), .rst(rst), .MEM_R_EN(r_en), .MEM_W_EN(w_en), .address(addr), .dataIn(din),
    .dataOut(dout), .ready(rdy), .busy(bsy), .addr_err(aerr)
  );
  data_mem_responder #(.LATENCY(1)) u1 (
    .clk(clk), .rst(rst), .MEM_R_EN(r1), .MEM_W_EN(w1), .address(a1), .dataIn(d1),
    .dataOut(dout1), .ready(rdy1), .busy(bsy1), .addr_err(aerr1)
  );

  task automatic chk(input string n, input logic [31:0] o, input logic [31:0] x);
    checks++;
    assert (o === x) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", n, o, x);
    end
  endtask

  task automatic op(input logic we, input logic re, input logic [31:0] a, input logic [31:0] d, input int drop);
    exp_t e;
    int c, idx;
    logic inr;
    inr = a >= 32'd1024 && ((a - 32'd1024) >> 2) < 32'd64;
    idx = int'((a - 32'd1024) >> 2);
    e.rd = !we;
    e.err = !inr;
    if (we) begin
      if (inr) model[idx] = d;
      e.data = last_rd;
    end else begin
      e.data = inr && model.exists(idx) ? model[idx] : 32'd0;
      last_rd = e.data;
    end
    sb.push_back(e);
    w_en = we; r_en = re; addr = a; din = d;
    c = 0;
    do begin
      @(posedge clk); #1;
      c++;
      if (c == 1) chk("busy_c1", 32'(bsy), 32'd1);
      if (drop != 0 && c == drop) begin w_en = 0; r_en = 0; end
    end while (!rdy && c < 20);
    w_en = 0; r_en = 0;
    chk("latency", 32'(c), 32'd4);
    chk("busy_at_ready", 32'(bsy), 32'd0);
    e = sb.pop_front();
    chk(e.rd ? "rd_err" : "wr_err", 32'(aerr), 32'(e.err));
    chk(e.rd ? "rd_data" : "wr_dout_held", dout, e.data);
    @(posedge clk); #1;
    chk("ready_pulse", 32'(rdy), 32'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(rdy), 32'd0);
    chk("rst_busy", 32'(bsy), 32'd0);
    chk("rst_err", 32'(aerr), 32'd0);
    chk("rst_dout", dout, 32'd0);
    rst = 1;
    @(posedge clk); #1;
    chk("idle_ready", 32'(rdy), 32'd0);
    op(1, 0, 32'd1024, 32'hDEADBEEF, 0);
    op(0, 1, 32'd1024, 32'd0, 0);
    op(1, 0, 32'd1276, 32'h12345678, 0);
    op(1, 0, 32'd1280, 32'hCAFEF00D, 0);
    op(0, 1, 32'd1276, 32'd0, 0);
    op(0, 1, 32'd1024, 32'd0, 0);
    op(0, 1, 32'd1020, 32'd0, 0);
    op(1, 0, 32'd1036, 32'h99, 2);
    op(0, 1, 32'd1036, 32'd0, 0);
    op(1, 1, 32'd1028, 32'h55, 0);
    op(0, 1, 32'd1028, 32'd0, 0);
    w_en = 1; addr = 32'd1032; din = 32'hAA;
    repeat (2) begin @(posedge clk); #1; end
    rst = 0;
    @(posedge clk); #1;
    rst = 1; w_en = 0;
    chk("midrst_ready", 32'(rdy), 32'd0);
    chk("midrst_busy", 32'(bsy), 32'd0);
    chk("midrst_dout", dout, 32'd0);
    model.delete();
    sb.delete();
    last_rd = 0;
    op(0, 1, 32'd1032, 32'd0, 0);
    op(0, 1, 32'd1024, 32'd0, 0);
    w1 = 1; a1 = 32'd1024; d1 = 32'h77;
    @(posedge clk); #1;
    chk("l1_wr_ready", 32'(rdy1), 32'd1);
    w1 = 0;
    @(posedge clk); #1;
    chk("l1_wr_gap", 32'(rdy1), 32'd0);
    r1 = 1;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk); #1;
      chk("l1_rd_ready", 32'(rdy1), 32'(i % 2));
      chk("l1_busy", 32'(bsy1), 32'd0);
      if (i % 2 == 1) chk("l1_rd_data", dout1, 32'h77);
    end
    r1 = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
